// File: rtl/serial_add_sched.sv
// serial_add_sched: two-requester round-robin scheduler sharing one fulladder.
// Optional SERIAL_ADD_SUB_EN adds per-requester subtract select (A-B).

module fulladder (
  input  logic A,
  input  logic B,
  input  logic C,
  output logic Y,
  output logic X
);

  assign Y = A ^ B ^ C;
  assign X = (A & B) | (C & (A ^ B));

endmodule

module serial_add_sched #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         REQ0_VALID,
  output logic         REQ0_READY,
  input  logic [W-1:0] REQ0_A,
  input  logic [W-1:0] REQ0_B,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         REQ0_SUB,
`endif
  input  logic         REQ1_VALID,
  output logic         REQ1_READY,
  input  logic [W-1:0] REQ1_A,
  input  logic [W-1:0] REQ1_B,
`ifdef SERIAL_ADD_SUB_EN
  input  logic         REQ1_SUB,
`endif
  output logic         RES_VALID,
  input  logic         RES_READY,
  output logic [W-1:0] RES_SUM,
  output logic         RES_COUT,
  output logic         RES_ID
);

  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [W-1:0]  sum_q;
  logic [W-1:0]  sum_nx;
  logic [CW-1:0] cnt_q;
  logic          carry_q;
  logic          id_q;
  logic          last_q;

  logic          acc;
  logic          sel;
  logic          sub_sel;
  logic [W-1:0]  op_a;
  logic [W-1:0]  op_b;
  logic          fa_y;
  logic          fa_x;

  fulladder u_fa (
    .A (a_q[0]),
    .B (b_q[0]),
    .C (carry_q),
    .Y (fa_y),
    .X (fa_x)
  );

`ifdef SERIAL_ADD_SUB_EN
  assign sub_sel = sel ? REQ1_SUB : REQ0_SUB;
`else
  assign sub_sel = 1'b0;
`endif

  // Subtraction is A + ~B + 1: invert B here, carry seeds the +1.
  assign op_a = sel ? REQ1_A : REQ0_A;
  assign op_b = (sel ? REQ1_B : REQ0_B) ^ {W{sub_sel}};

  // Sum bit enters at the MSB so the LSB lands at bit 0 after W shifts.
  generate
    if (W == 1) begin : g_sum1
      assign sum_nx = fa_y;
    end else begin : g_sumw
      assign sum_nx = {fa_y, sum_q[W-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, round-robin grant and handshake outputs.
  always_comb begin
    state_d    = state_q;
    REQ0_READY = 1'b0;
    REQ1_READY = 1'b0;
    RES_VALID  = 1'b0;
    acc        = 1'b0;
    sel        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (REQ0_VALID && (!REQ1_VALID || last_q)) begin
          REQ0_READY = 1'b1;
          acc        = 1'b1;
          sel        = 1'b0;
          state_d    = RUN;
        end else if (REQ1_VALID) begin
          REQ1_READY = 1'b1;
          acc        = 1'b1;
          sel        = 1'b1;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (cnt_q == CW'(W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        RES_VALID = 1'b1;
        if (RES_READY) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Operand latch on grant, then one bit per cycle through the adder.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= 1'b0;
      last_q  <= 1'b1;
    end else if (acc) begin
      a_q     <= op_a;
      b_q     <= op_b;
      cnt_q   <= '0;
      carry_q <= sub_sel;
      id_q    <= sel;
      last_q  <= sel;
    end else if (state_q == RUN) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      sum_q   <= sum_nx;
      cnt_q   <= cnt_q + CW'(1);
      carry_q <= fa_x;
    end
  end

  assign RES_SUM  = sum_q;
  assign RES_COUT = carry_q;
  assign RES_ID   = id_q;

endmodule

// File: tb/tb_serial_add_sched.sv
// tb_serial_add_sched: directed stimulus, cycle model and literal checks.
// Define SERIAL_ADD_SUB_EN to exercise the subtract ports.

module tb_serial_add_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         v0 = 1'b0;
  logic         v1 = 1'b0;
  logic         r0;
  logic         r1;
  logic [W-1:0] a0 = '0;
  logic [W-1:0] b0 = '0;
  logic [W-1:0] a1 = '0;
  logic [W-1:0] b1 = '0;
  logic         s0 = 1'b0;
  logic         s1 = 1'b0;
  logic         res_valid;
  logic         res_ready = 1'b1;
  logic [W-1:0] res_sum;
  logic         res_cout;
  logic         res_id;

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  serial_add_sched #(.W(W)) dut (
    .CLK        (clk),
    .RST        (rst),
    .REQ0_VALID (v0),
    .REQ0_READY (r0),
    .REQ0_A     (a0),
    .REQ0_B     (b0),
`ifdef SERIAL_ADD_SUB_EN
    .REQ0_SUB   (s0),
`endif
    .REQ1_VALID (v1),
    .REQ1_READY (r1),
    .REQ1_A     (a1),
    .REQ1_B     (b1),
`ifdef SERIAL_ADD_SUB_EN
    .REQ1_SUB   (s1),
`endif
    .RES_VALID  (res_valid),
    .RES_READY  (res_ready),
    .RES_SUM    (res_sum),
    .RES_COUT   (res_cout),
    .RES_ID     (res_id)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Model: 0 idle, 1 computing (m_cnt cycles left), 2 holding a result.
  int           m_phase = 0;
  int           m_cnt = 0;
  bit           m_last = 1'b1;
  logic [W-1:0] m_sum = '0;
  bit           m_cout = 1'b0;
  bit           m_id = 1'b0;
  bit           m_any;
  bit           m_g;
  logic [W-1:0] ea;
  logic [W-1:0] eb;
  bit           es;

  function automatic bit win_any(input bit va, input bit vb);
    return va || vb;
  endfunction

  function automatic bit win_id(input bit va, input bit vb, input bit last);
    if (va && vb) return !last;
    return vb;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0;
      m_cnt   = 0;
      m_last  = 1'b1;
    end else begin
      cyc++;
      case (m_phase)
        0: begin
          m_any = win_any(v0, v1);
          m_g   = win_id(v0, v1, m_last);
          if (m_any) begin
            ea = m_g ? a1 : a0;
            eb = m_g ? b1 : b0;
            es = m_g ? s1 : s0;
            if (es) begin
              m_sum  = ea - eb;
              m_cout = (ea >= eb);
            end else begin
              {m_cout, m_sum} = {1'b0, ea} + {1'b0, eb};
            end
            m_id    = m_g;
            m_last  = m_g;
            m_phase = 1;
            m_cnt   = W;
          end
        end
        1: begin
          m_cnt--;
          if (m_cnt == 0) m_phase = 2;
        end
        default: begin
          if (res_ready) m_phase = 0;
        end
      endcase
    end
  end

  // Compare every cycle against the model; reset values while in reset.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_ready0", r0, 0);
      check("rst_ready1", r1, 0);
      check("rst_valid", res_valid, 0);
      check("rst_sum", res_sum, 0);
      check("rst_cout", res_cout, 0);
      check("rst_id", res_id, 0);
    end else begin
      check("ready0", r0,
            (m_phase == 0) && win_any(v0, v1) && !win_id(v0, v1, m_last));
      check("ready1", r1,
            (m_phase == 0) && win_any(v0, v1) && win_id(v0, v1, m_last));
      check("res_valid", res_valid, m_phase == 2);
      if (m_phase == 2) begin
        check("res_sum", res_sum, m_sum);
        check("res_cout", res_cout, m_cout);
        check("res_id", res_id, m_id);
      end
    end
  end

  // Call at #1 after a rising edge; returns at #1 after the accept edge.
  task automatic req(input bit id, input logic [W-1:0] a,
                     input logic [W-1:0] b, input bit sub,
                     output int acc_cyc);
    if (id) begin
      a1 = a; b1 = b; s1 = sub; v1 = 1'b1;
    end else begin
      a0 = a; b0 = b; s0 = sub; v0 = 1'b1;
    end
    acc_cyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((id ? r1 : r0) === 1'b1) begin
        acc_cyc = cyc;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (acc_cyc < 0) check("accept_timeout", 0, 1);
    @(posedge clk);
    #1;
    if (id) v1 = 1'b0;
    else v0 = 1'b0;
  endtask

  // Returns at the negedge where RES_VALID is first seen high.
  task automatic wait_valid(output int vcyc);
    vcyc = -1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        vcyc = cyc;
        break;
      end
    end
    if (vcyc < 0) check("valid_timeout", 0, 1);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t_acc;
    int t_val;
    int ng;
    int gcyc[4];
    bit gid[4];
    bit exp_g[4];
    exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // 0x5A + 0x3C from requester 0; result W+1 cycles after accept.
    req(1'b0, 8'h5A, 8'h3C, 1'b0, t_acc);
    wait_valid(t_val);
    check("t1_latency", t_val - t_acc, 9);
    check("t1_sum", res_sum, 8'h96);
    check("t1_cout", res_cout, 0);
    check("t1_id", res_id, 0);
    next_cycle();

    // 0xFF + 0x01 from requester 1 wraps with carry out.
    req(1'b1, 8'hFF, 8'h01, 1'b0, t_acc);
    wait_valid(t_val);
    check("t2_sum", res_sum, 8'h00);
    check("t2_cout", res_cout, 1);
    check("t2_id", res_id, 1);
    next_cycle();

    // Both requesters held valid: grants alternate every W+2 cycles.
    a0 = 8'h11; b0 = 8'h22; s0 = 1'b0;
    a1 = 8'h33; b1 = 8'h44; s1 = 1'b0;
    v0 = 1'b1; v1 = 1'b1;
    ng = 0;
    for (int i = 0; i < 60 && ng < 4; i++) begin
      @(negedge clk);
      if (r0 === 1'b1 || r1 === 1'b1) begin
        gcyc[ng] = cyc;
        gid[ng] = (r1 === 1'b1);
        ng++;
      end
    end
    check("t3_grants", ng, 4);
    next_cycle();
    v0 = 1'b0; v1 = 1'b0;
    for (int i = 0; i < ng; i++) check("t3_order", gid[i], exp_g[i]);
    for (int i = 1; i < ng; i++) check("t3_spacing", gcyc[i] - gcyc[i-1], 12 - 2);
    wait_valid(t_val);
    check("t3_last_sum", res_sum, 8'h77);
    check("t3_last_id", res_id, 1);
    next_cycle();

    // Backpressure: result held, no grants while valids stay high.
    res_ready = 1'b0;
    req(1'b0, 8'hC8, 8'h64, 1'b0, t_acc);
    v0 = 1'b1; v1 = 1'b1;
    wait_valid(t_val);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_valid_hold", res_valid, 1);
      check("t4_sum_hold", res_sum, 8'h2C);
      check("t4_cout_hold", res_cout, 1);
      check("t4_ready0", r0, 0);
      check("t4_ready1", r1, 0);
    end
    next_cycle();
    v0 = 1'b0; v1 = 1'b0;
    res_ready = 1'b1;
    next_cycle();

    // Reset three cycles into a run aborts it.
    req(1'b1, 8'h0F, 8'h01, 1'b0, t_acc);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t5_rst_valid", res_valid, 0);
    check("t5_rst_sum", res_sum, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("t5_no_valid", res_valid, 0);
    end
    next_cycle();
    req(1'b0, 8'h12, 8'h34, 1'b0, t_acc);
    wait_valid(t_val);
    check("t5_sum", res_sum, 8'h46);
    check("t5_cout", res_cout, 0);
    check("t5_id", res_id, 0);
    next_cycle();

    // Carry boundaries.
    req(1'b0, 8'h80, 8'h80, 1'b0, t_acc);
    wait_valid(t_val);
    check("t6_sum", res_sum, 8'h00);
    check("t6_cout", res_cout, 1);
    next_cycle();
    req(1'b1, 8'hFF, 8'hFF, 1'b0, t_acc);
    wait_valid(t_val);
    check("t7_sum", res_sum, 8'hFE);
    check("t7_cout", res_cout, 1);
    check("t7_id", res_id, 1);
    next_cycle();

`ifdef SERIAL_ADD_SUB_EN
    req(1'b0, 8'h10, 8'h01, 1'b1, t_acc);
    wait_valid(t_val);
    check("t8_sub_sum", res_sum, 8'h0F);
    check("t8_sub_cout", res_cout, 1);
    next_cycle();
    req(1'b1, 8'h01, 8'h02, 1'b1, t_acc);
    wait_valid(t_val);
    check("t9_sub_sum", res_sum, 8'hFF);
    check("t9_sub_cout", res_cout, 0);
    next_cycle();
    s0 = 1'b0; s1 = 1'b0;
`endif

    repeat (3) next_cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
